// File: rtl/comp_arb_seq_if.sv
// Request/result bus between the requesters and the shared serial comparator.
// The master modport is the requester/consumer side; the slave modport is the arbiter.
interface comp_arb_seq_if #(
  parameter int NREQ   = 2,
  parameter int DATA_W = 8
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]        req;
  logic [NREQ*DATA_W-1:0] a_in;
  logic [NREQ*DATA_W-1:0] b_in;
  logic [NREQ-1:0]        gnt;
  logic                   busy;
  logic                   res_valid;
  logic                   res_ready;
  logic [IDW-1:0]         res_id;
  logic                   res_g;
  logic                   res_l;
  logic                   res_e;

  modport master (
    output req, a_in, b_in, res_ready,
    input  gnt, busy, res_valid, res_id, res_g, res_l, res_e
  );

  modport slave (
    input  req, a_in, b_in, res_ready,
    output gnt, busy, res_valid, res_id, res_g, res_l, res_e
  );
endinterface

// File: rtl/comp_arb_seq.sv
// Round-robin arbiter in front of one CHUNK_W-bit magnitude-compare slice.
// The winner's operands are compared MSB chunk first, stopping at the first unequal chunk.
module comp_arb_seq #(
  parameter int NREQ    = 2,
  parameter int DATA_W  = 8,
  parameter int CHUNK_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  comp_arb_seq_if.slave   bus
);
  localparam int NCHUNK = DATA_W / CHUNK_W;
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CIW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [NREQ-1:0] GNT_ONE = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [IDW-1:0]     r_rr_ptr;
  logic [CIW-1:0]     r_idx;
  logic [DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_b;
  logic [IDW-1:0]     r_id;
  logic               r_res_valid;
  logic               r_res_g;
  logic               r_res_l;
  logic               r_res_e;

  logic               w_found;
  logic [IDW-1:0]     w_win;
  logic [IDW-1:0]     w_cand;
  logic               w_hit;
  logic [CHUNK_W-1:0] w_ca;
  logic [CHUNK_W-1:0] w_cb;

  // Round-robin search starting at r_rr_ptr; the first hit wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    w_hit   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      w_cand  = IDW'((int'(r_rr_ptr) + i) % NREQ);
      w_hit   = bus.req[w_cand] & ~w_found;
      w_win   = w_hit ? w_cand : w_win;
      w_found = w_found | w_hit;
    end
  end

  assign w_ca = r_a[r_idx*CHUNK_W +: CHUNK_W];
  assign w_cb = r_b[r_idx*CHUNK_W +: CHUNK_W];

  // The grant is combinational so the requester sees it in the cycle its operands are latched.
  assign bus.gnt       = (r_state == IDLE && w_found && !rst) ? (GNT_ONE << w_win) : '0;
  assign bus.busy      = (r_state != IDLE);
  assign bus.res_valid = r_res_valid;
  assign bus.res_id    = r_id;
  assign bus.res_g     = r_res_g;
  assign bus.res_l     = r_res_l;
  assign bus.res_e     = r_res_e;

  // Arbitration / serial compare FSM with registered result flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_idx       <= CIW'(NCHUNK-1);
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= '0;
      r_res_valid <= 1'b0;
      r_res_g     <= 1'b0;
      r_res_l     <= 1'b0;
      r_res_e     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_a      <= bus.a_in[w_win*DATA_W +: DATA_W];
            r_b      <= bus.b_in[w_win*DATA_W +: DATA_W];
            r_id     <= w_win;
            r_rr_ptr <= (w_win == IDW'(NREQ-1)) ? '0 : w_win + IDW'(1);
            r_idx    <= CIW'(NCHUNK-1);
            r_state  <= CMP;
          end else begin
            r_state  <= IDLE;
          end
        end
        CMP: begin
          if (w_ca > w_cb) begin
            r_res_g     <= 1'b1;
            r_res_valid <= 1'b1;
            r_state     <= DONE;
          end else if (w_ca < w_cb) begin
            r_res_l     <= 1'b1;
            r_res_valid <= 1'b1;
            r_state     <= DONE;
          end else if (r_idx == '0) begin
            r_res_e     <= 1'b1;
            r_res_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_idx       <= r_idx - CIW'(1);
            r_state     <= CMP;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_res_g     <= 1'b0;
            r_res_l     <= 1'b0;
            r_res_e     <= 1'b0;
            r_state     <= IDLE;
          end else begin
            r_state     <= DONE;
          end
        end
        default: begin
          r_res_valid <= 1'b0;
          r_res_g     <= 1'b0;
          r_res_l     <= 1'b0;
          r_res_e     <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_comp_arb_seq.sv
// Directed bench for comp_arb_seq: a vector table for single compares plus
// hand-written reset, round-robin, backpressure and mid-operation reset sequences.
module tb_comp_arb_seq;
  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_fail;

  comp_arb_seq_if #(.NREQ(2), .DATA_W(8)) bus ();

  comp_arb_seq #(.NREQ(2), .DATA_W(8), .CHUNK_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic       g;
    logic       l;
    logic       e;
    int         k;
  } vec_t;

  vec_t vecs[6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index; a value sampled on the falling edge belongs to cycle cyc.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_ops(input int id, input logic [7:0] a, input logic [7:0] b);
    bus.a_in[id*8 +: 8] = a;
    bus.b_in[id*8 +: 8] = b;
  endtask

  task automatic wait_gnt(output int t, output bit ok);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.gnt != 2'b00) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
    end
    if (!ok) chk("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid(output int t, output bit ok);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.res_valid) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
    end
    if (!ok) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  // Let any outstanding result drain with res_ready high.
  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.busy && !bus.res_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int t_g;
    int t_v;
    bit ok;
    @(posedge clk); #1;
    set_ops(v.id, v.a, v.b);
    bus.req = 2'b01 << v.id;
    wait_gnt(t_g, ok);
    if (ok) begin
      chk($sformatf("v%0d_gnt", n), 32'(bus.gnt), 32'(2'b01 << v.id));
      @(posedge clk); #1;
      bus.req = 2'b00;
      wait_valid(t_v, ok);
      if (ok) begin
        chk($sformatf("v%0d_latency", n), 32'(t_v - t_g), 32'(v.k + 1));
        chk($sformatf("v%0d_id", n), 32'(bus.res_id), 32'(v.id));
        chk($sformatf("v%0d_gle", n), {29'd0, bus.res_g, bus.res_l, bus.res_e},
            {29'd0, v.g, v.l, v.e});
        @(negedge clk);
        chk($sformatf("v%0d_post", n), {28'd0, bus.res_valid, bus.res_g, bus.res_l, bus.res_e},
            32'd0);
      end
    end
    bus.req = 2'b00;
    drain();
  endtask

  initial begin
    int  t_g;
    int  t_v;
    int  n_g;
    int  last_hs;
    bit  ok;
    logic [1:0] exp_g;

    cyc            = 0;
    n_chk          = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bus.req        = 2'b11;
    bus.a_in       = 16'h0000;
    bus.b_in       = 16'h0000;
    bus.res_ready  = 1'b1;

    vecs[0] = '{id: 0, a: 8'hA5, b: 8'hA5, g: 1'b0, l: 1'b0, e: 1'b1, k: 4};
    vecs[1] = '{id: 1, a: 8'h80, b: 8'h7F, g: 1'b1, l: 1'b0, e: 1'b0, k: 1};
    vecs[2] = '{id: 0, a: 8'h12, b: 8'h13, g: 1'b0, l: 1'b1, e: 1'b0, k: 4};
    vecs[3] = '{id: 1, a: 8'hC0, b: 8'hF0, g: 1'b0, l: 1'b1, e: 1'b0, k: 2};
    vecs[4] = '{id: 0, a: 8'h3C, b: 8'h38, g: 1'b1, l: 1'b0, e: 1'b0, k: 3};
    vecs[5] = '{id: 1, a: 8'h00, b: 8'h00, g: 1'b0, l: 1'b0, e: 1'b1, k: 4};

    // Reset held two cycles with both requests asserted.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_gnt", 32'(bus.gnt), 32'd0);
      chk("rst_valid_busy", {30'd0, bus.res_valid, bus.busy}, 32'd0);
      chk("rst_flags", {29'd0, bus.res_g, bus.res_l, bus.res_e}, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_first_gnt", 32'(bus.gnt), 32'(2'b01));
    @(posedge clk); #1;
    bus.req = 2'b00;
    drain();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Round-robin with both requests held; rr_ptr is 0 after the last id1 vector.
    @(posedge clk); #1;
    set_ops(0, 8'h00, 8'h00);
    set_ops(1, 8'h00, 8'h00);
    bus.req = 2'b11;
    n_g     = 0;
    last_hs = -10;
    exp_g   = 2'b01;
    for (int i = 0; i < 60 && n_g < 4; i++) begin
      @(negedge clk);
      if (bus.gnt != 2'b00) begin
        chk($sformatf("rr_order%0d", n_g), 32'(bus.gnt), 32'(exp_g));
        if (n_g > 0) chk($sformatf("rr_spacing%0d", n_g), 32'(cyc), 32'(last_hs + 1));
        exp_g = {exp_g[0], exp_g[1]};
        n_g++;
      end
      if (bus.res_valid && bus.res_ready) last_hs = cyc;
    end
    chk("rr_count", 32'(n_g), 32'd4);
    @(posedge clk); #1;
    bus.req = 2'b00;
    drain();

    // Backpressure: result held three cycles while req1 waits.
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    set_ops(0, 8'h80, 8'h7F);
    set_ops(1, 8'h11, 8'h22);
    bus.req = 2'b01;
    wait_gnt(t_g, ok);
    chk("bp_gnt0", 32'(bus.gnt), 32'(2'b01));
    @(posedge clk); #1;
    bus.req = 2'b10;
    wait_valid(t_v, ok);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold", {26'd0, bus.gnt, bus.res_valid, bus.res_id, bus.res_g, bus.res_l, bus.res_e},
          {26'd0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_cycle", {29'd0, bus.gnt, bus.res_valid}, {29'd0, 2'b00, 1'b1});
    @(negedge clk);
    chk("bp_gnt1", {29'd0, bus.gnt, bus.res_valid}, {29'd0, 2'b10, 1'b0});
    @(posedge clk); #1;
    bus.req = 2'b00;
    drain();

    // Mid-operation reset; id0 granted first so rr_ptr is 1 before the reset.
    @(posedge clk); #1;
    set_ops(0, 8'h00, 8'h00);
    bus.req = 2'b01;
    wait_gnt(t_g, ok);
    @(posedge clk); #1;
    bus.req = 2'b00;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mr_busy", {30'd0, bus.busy, bus.res_valid}, 32'd0);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.res_valid) ok = 1'b1;
    end
    chk("mr_no_result", 32'(ok), 32'd0);
    @(posedge clk); #1;
    bus.req = 2'b11;
    @(negedge clk);
    chk("mr_rrptr", 32'(bus.gnt), 32'(2'b01));
    @(posedge clk); #1;
    bus.req = 2'b00;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
